// File: rtl/vxe_intr_servicer.sv
`default_nettype none
// vxe_intr_servicer: picks one pending interrupt, hands its index downstream, acks it, then settles.
// Option macro VXE_INTR_SERVICER_RR_EN selects round-robin instead of fixed priority.  Rev 1.0
module vxe_intr_servicer #(
   parameter  int NR_INT     = 4,
   parameter  int SETTLE_CYC = 2,
   localparam int IDW        = $clog2(NR_INT)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              i_intr,
   input  logic [NR_INT-1:0] i_active,
   output logic              o_ack_en,
   output logic [NR_INT-1:0] o_ack,
   output logic              o_evt_vld,
   output logic [IDW-1:0]    o_evt_id,
   input  logic              i_evt_rdy,
   output logic              o_busy,
   output logic [7:0]        o_spur_cnt
);

   localparam int SCW = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DELIVER = 2'd1,
      S_ACK     = 2'd2,
      S_SETTLE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [SCW-1:0]    settle_cnt;
   logic [SCW-1:0]    settle_nx;
   logic              ack_en_nx;
   logic [NR_INT-1:0] ack_nx;
   logic              evt_vld_nx;
   logic [IDW-1:0]    evt_id_nx;
   logic              busy_nx;
   logic [7:0]        spur_nx;
   logic [IDW-1:0]    sel_id;
   logic              sel_found;

`ifdef VXE_INTR_SERVICER_RR_EN
   logic [IDW-1:0]    ptr;
   logic [IDW-1:0]    ptr_nx;

   // Modular increment that also handles non-power-of-two source counts.
   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NR_INT) begin
         sum = sum - NR_INT;
      end
      return IDW'(sum);
   endfunction

   // Descending scan so the smallest offset from the pointer is written last and wins.
   always_comb begin
      sel_id    = '0;
      sel_found = 1'b0;
      for (int i = NR_INT - 1; i >= 0; i--) begin
         if (i_active[wrap_add(ptr, i)]) begin
            sel_id    = wrap_add(ptr, i);
            sel_found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      sel_id    = '0;
      sel_found = 1'b0;
      for (int i = NR_INT - 1; i >= 0; i--) begin
         if (i_active[i]) begin
            sel_id    = IDW'(i);
            sel_found = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_nx   = state;
      settle_nx  = settle_cnt;
      ack_en_nx  = 1'b0;
      ack_nx     = '0;
      evt_vld_nx = o_evt_vld;
      evt_id_nx  = o_evt_id;
      spur_nx    = o_spur_cnt;
`ifdef VXE_INTR_SERVICER_RR_EN
      ptr_nx     = ptr;
`endif
      unique case (state)
         S_IDLE: begin
            if (i_intr) begin
               if (sel_found) begin
                  state_nx   = S_DELIVER;
                  evt_vld_nx = 1'b1;
                  evt_id_nx  = sel_id;
               end else if (o_spur_cnt != 8'hFF) begin
                  spur_nx = o_spur_cnt + 8'd1;
               end
            end
         end
         S_DELIVER: begin
            if (o_evt_vld && i_evt_rdy) begin
               state_nx   = S_ACK;
               evt_vld_nx = 1'b0;
               ack_en_nx  = 1'b1;
               ack_nx     = {{(NR_INT-1){1'b0}}, 1'b1} << o_evt_id;
            end
         end
         S_ACK: begin
            state_nx  = S_SETTLE;
            settle_nx = SCW'(SETTLE_CYC);
`ifdef VXE_INTR_SERVICER_RR_EN
            ptr_nx    = wrap_add(o_evt_id, 1);
`endif
         end
         S_SETTLE: begin
            // The line is deliberately not looked at here; the source unit needs these cycles to drop it.
            if (settle_cnt <= SCW'(1)) begin
               state_nx  = S_IDLE;
               settle_nx = '0;
            end else begin
               settle_nx = settle_cnt - SCW'(1);
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
      busy_nx = (state_nx != S_IDLE);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= S_IDLE;
         settle_cnt <= '0;
         o_ack_en   <= 1'b0;
         o_ack      <= '0;
         o_evt_vld  <= 1'b0;
         o_evt_id   <= '0;
         o_busy     <= 1'b0;
         o_spur_cnt <= '0;
      end else begin
         state      <= state_nx;
         settle_cnt <= settle_nx;
         o_ack_en   <= ack_en_nx;
         o_ack      <= ack_nx;
         o_evt_vld  <= evt_vld_nx;
         o_evt_id   <= evt_id_nx;
         o_busy     <= busy_nx;
         o_spur_cnt <= spur_nx;
      end
   end

`ifdef VXE_INTR_SERVICER_RR_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_nx;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vxe_intr_servicer.sv
`default_nettype none
// tb_vxe_intr_servicer: directed scenarios plus randomized events checked against a transaction-level model.
module tb_vxe_intr_servicer;
   localparam int NR     = 4;
   localparam int SETTLE = 2;
   localparam int IDW    = $clog2(NR);

   logic           clk = 1'b0;
   logic           nrst;
   logic           intr;
   logic [NR-1:0]  active;
   logic           ack_en;
   logic [NR-1:0]  ack;
   logic           evt_vld;
   logic [IDW-1:0] evt_id;
   logic           evt_rdy;
   logic           busy;
   logic [7:0]     spur_cnt;

   int checks = 0;
   int errors = 0;
   int model_ptr  = 0;
   int model_spur = 0;

   always #5 clk = ~clk;

   vxe_intr_servicer #(.NR_INT(NR), .SETTLE_CYC(SETTLE)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .i_intr     (intr),
      .i_active   (active),
      .o_ack_en   (ack_en),
      .o_ack      (ack),
      .o_evt_vld  (evt_vld),
      .o_evt_id   (evt_id),
      .i_evt_rdy  (evt_rdy),
      .o_busy     (busy),
      .o_spur_cnt (spur_cnt)
   );

   // Which source the servicer should pick for a given pending vector.
   function automatic int ref_sel(input logic [NR-1:0] act, input int ptr);
      int start;
`ifdef VXE_INTR_SERVICER_RR_EN
      start = ptr;
`else
      start = 0;
`endif
      for (int i = 0; i < NR; i++) begin
         if (act[(start + i) % NR]) return (start + i) % NR;
      end
      return -1;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      nrst = 1'b0; intr = 1'b0; active = '0; evt_rdy = 1'b0;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      model_ptr  = 0;
      model_spur = 0;
   endtask

   // One serviced interrupt from IDLE back to IDLE, checking every phase.
   task automatic do_event(input logic [NR-1:0] act, input int stall, output int got_id);
      int            exp_id;
      logic [NR-1:0] exp_ack;
      exp_id  = ref_sel(act, model_ptr);
      exp_ack = NR'(1) << exp_id;
      intr = 1'b1; active = act; evt_rdy = 1'b0;
      @(negedge clk);
      got_id = int'(evt_id);
      checks++;
      if (evt_vld !== 1'b1 || evt_id !== IDW'(exp_id) || busy !== 1'b1) begin
         errors++;
         $display("FAIL deliver: vld=%b id=%0d busy=%b, expected vld=1 id=%0d busy=1 (act=%b)",
                  evt_vld, evt_id, busy, exp_id, act);
      end
      intr = 1'b0; active = NR'($urandom);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         checks++;
         if (evt_vld !== 1'b1 || evt_id !== IDW'(exp_id) || ack_en !== 1'b0) begin
            errors++;
            $display("FAIL hold: vld=%b id=%0d ack_en=%b, expected vld=1 id=%0d ack_en=0",
                     evt_vld, evt_id, ack_en, exp_id);
         end
         active = NR'($urandom);
      end
      evt_rdy = 1'b1;
      @(negedge clk);
      evt_rdy = 1'b0;
      checks++;
      if (ack_en !== 1'b1 || ack !== exp_ack || evt_vld !== 1'b0) begin
         errors++;
         $display("FAIL ack: ack_en=%b ack=%b vld=%b, expected ack_en=1 ack=%b vld=0",
                  ack_en, ack, evt_vld, exp_ack);
      end
      model_ptr = (exp_id + 1) % NR;
      intr = 1'b1; active = NR'($urandom_range(1, (1 << NR) - 1));
      for (int k = 1; k <= SETTLE; k++) begin
         @(negedge clk);
         checks++;
         if (ack_en !== 1'b0 || ack !== '0 || evt_vld !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL settle%0d: ack_en=%b ack=%b vld=%b busy=%b, expected 0 0 0 1",
                     k, ack_en, ack, evt_vld, busy);
         end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || evt_vld !== 1'b0) begin
         errors++;
         $display("FAIL idle_return: busy=%b vld=%b, expected 0 0", busy, evt_vld);
      end
      intr = 1'b0; active = '0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (ack_en !== 1'b0 || ack !== '0 || evt_vld !== 1'b0 || evt_id !== '0 ||
          busy !== 1'b0 || spur_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset: ack_en=%b ack=%b vld=%b id=%0d busy=%b spur=%0d, expected all 0",
                  ack_en, ack, evt_vld, evt_id, busy, spur_cnt);
      end
   endtask

   task automatic test_basic();
      int id;
      apply_reset();
      do_event(4'b1010, 0, id);
      checks++;
      if (id !== 1) begin errors++; $display("FAIL basic_first: id=%0d, expected 1", id); end
      do_event(4'b1000, 0, id);
      checks++;
      if (id !== 3) begin errors++; $display("FAIL basic_second: id=%0d, expected 3", id); end
   endtask

   task automatic test_backpressure();
      int id;
      do_event(4'b0100, 5, id);
      checks++;
      if (id !== 2) begin errors++; $display("FAIL backpressure_id: id=%0d, expected 2", id); end
   endtask

   task automatic test_priority();
      int id;
      int exp_ids[3];
`ifdef VXE_INTR_SERVICER_RR_EN
      exp_ids = '{0, 1, 0};
`else
      exp_ids = '{0, 0, 0};
`endif
      apply_reset();
      for (int e = 0; e < 3; e++) begin
         do_event(4'b0011, 0, id);
         checks++;
         if (id !== exp_ids[e]) begin
            errors++;
            $display("FAIL priority_evt%0d: id=%0d, expected %0d", e, id, exp_ids[e]);
         end
      end
   endtask

   task automatic test_spurious();
      logic vld_seen;
      apply_reset();
      vld_seen = 1'b0;
      intr = 1'b1; active = '0;
      repeat (3) begin
         @(negedge clk);
         if (evt_vld !== 1'b0 || busy !== 1'b0) vld_seen = 1'b1;
      end
      checks++;
      if (spur_cnt !== 8'd3) begin errors++; $display("FAIL spur3: cnt=%0d, expected 3", spur_cnt); end
      repeat (300) begin
         @(negedge clk);
         if (evt_vld !== 1'b0 || busy !== 1'b0) vld_seen = 1'b1;
      end
      intr = 1'b0;
      checks++;
      if (spur_cnt !== 8'd255) begin errors++; $display("FAIL spur_sat: cnt=%0d, expected 255", spur_cnt); end
      checks++;
      if (vld_seen !== 1'b0) begin errors++; $display("FAIL spur_novld: vld/busy seen=%b, expected 0", vld_seen); end
      model_spur = 255;
   endtask

   task automatic test_reset_midop();
      logic ack_seen;
      int   id;
      apply_reset();
      ack_seen = 1'b0;
      intr = 1'b1; active = '0;
      @(negedge clk);
      active = 4'b0100;
      @(negedge clk);
      checks++;
      if (evt_vld !== 1'b1 || spur_cnt !== 8'd1) begin
         errors++;
         $display("FAIL midop_setup: vld=%b spur=%0d, expected 1 1", evt_vld, spur_cnt);
      end
      intr = 1'b0; evt_rdy = 1'b1;
      #2 nrst = 1'b0;
      #1;
      checks++;
      if (ack_en !== 1'b0 || ack !== '0 || evt_vld !== 1'b0 || evt_id !== '0 ||
          busy !== 1'b0 || spur_cnt !== 8'd0) begin
         errors++;
         $display("FAIL midop_async: ack_en=%b ack=%b vld=%b id=%0d busy=%b spur=%0d, expected all 0",
                  ack_en, ack, evt_vld, evt_id, busy, spur_cnt);
      end
      repeat (3) begin
         @(negedge clk);
         if (ack_en !== 1'b0) ack_seen = 1'b1;
      end
      nrst = 1'b1; evt_rdy = 1'b0;
      model_ptr = 0; model_spur = 0;
      repeat (2) begin
         @(negedge clk);
         if (ack_en !== 1'b0 || evt_vld !== 1'b0) ack_seen = 1'b1;
      end
      checks++;
      if (ack_seen !== 1'b0) begin errors++; $display("FAIL midop_noack: ack/vld seen=%b, expected 0", ack_seen); end
      do_event(4'b0100, 1, id);
      checks++;
      if (id !== 2) begin errors++; $display("FAIL midop_resume: id=%0d, expected 2", id); end
   endtask

   task automatic test_back_to_back();
      logic prev_ack;
      logic prev_vld;
      int   last_ack;
      int   n_ack;
      prev_ack = 1'b0; prev_vld = 1'b0; last_ack = 0; n_ack = 0;
      intr = 1'b1; active = 4'b0001; evt_rdy = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         checks++;
         if (ack_en === 1'b1 && prev_ack === 1'b1) begin
            errors++;
            $display("FAIL b2b_ackwidth: ack_en high two cycles at cycle %0d, expected one", c);
         end
         if (ack_en === 1'b1) begin
            checks++;
            if (ack !== 4'b0001) begin errors++; $display("FAIL b2b_ack: ack=%b, expected 0001", ack); end
            if (prev_ack !== 1'b1) begin n_ack++; last_ack = c; end
         end
         if (evt_vld === 1'b1 && prev_vld !== 1'b1 && n_ack > 0) begin
            checks++;
            if (c - last_ack < SETTLE + 1) begin
               errors++;
               $display("FAIL b2b_gap: new vld %0d cycles after ack, expected at least %0d",
                        c - last_ack, SETTLE + 1);
            end
         end
         prev_ack = ack_en; prev_vld = evt_vld;
      end
      intr = 1'b0; active = '0;
      checks++;
      if (n_ack < 3) begin errors++; $display("FAIL b2b_count: acks=%0d, expected at least 3", n_ack); end
      for (int w = 0; w < 10 && busy !== 1'b0; w++) @(negedge clk);
      evt_rdy = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: busy=%b, expected 0", busy); end
      model_ptr = 1 % NR;
   endtask

   task automatic test_random();
      logic [NR-1:0] act;
      int            id;
      for (int it = 0; it < 60; it++) begin
         act = NR'($urandom);
         if ($urandom_range(0, 3) == 0) act = '0;
         if (act == '0) begin
            intr = 1'b1; active = '0;
            @(negedge clk);
            intr = 1'b0;
            model_spur = (model_spur < 255) ? model_spur + 1 : 255;
            checks++;
            if (spur_cnt !== 8'(model_spur) || evt_vld !== 1'b0 || busy !== 1'b0) begin
               errors++;
               $display("FAIL rand_spur: cnt=%0d vld=%b busy=%b, expected cnt=%0d vld=0 busy=0",
                        spur_cnt, evt_vld, busy, model_spur);
            end
         end else begin
            do_event(act, int'($urandom_range(0, 3)), id);
         end
         repeat ($urandom_range(0, 2)) begin
            active = NR'($urandom);
            @(negedge clk);
         end
         active = '0;
         checks++;
         if (evt_vld !== 1'b0 || busy !== 1'b0 || spur_cnt !== 8'(model_spur)) begin
            errors++;
            $display("FAIL rand_gap: vld=%b busy=%b cnt=%0d, expected 0 0 %0d",
                     evt_vld, busy, spur_cnt, model_spur);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached after %0d checks", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b0; intr = 1'b0; active = '0; evt_rdy = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_priority();
      test_spurious();
      test_reset_midop();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
